// File: rtl/mux_stream_nx1_pkg.sv
// rtl/mux_stream_nx1_pkg.sv - shared constants and helpers for the N-to-1 stream mux
package mux_stream_nx1_pkg;

  localparam int MODE_SEL = 0;
  localparam int MODE_RR  = 1;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mux_stream_nx1_rr_grant.sv
// rtl/mux_stream_nx1_rr_grant.sv - combinational round-robin arbiter starting at ptr
module rr_grant
  import mux_stream_nx1_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = sel_width(N)
) (
  input  logic [N-1:0]    valid,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] idx
);

  int              j;
  logic [SELW-1:0] jj;
  logic            found;

  // Scan ptr, ptr+1, ..., wrapping at N; the first valid channel wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    jj    = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      jj = SELW'(j);
      if (!found && valid[jj]) begin
        found   = 1'b1;
        gnt[jj] = 1'b1;
        idx     = jj;
      end
    end
  end

endmodule

// File: rtl/mux_stream_nx1.sv
// rtl/mux_stream_nx1.sv - registered N-to-1 stream mux, explicit select or round-robin
module mux_stream_nx1
  import mux_stream_nx1_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int N     = 4,
  parameter int MODE  = MODE_SEL,
  localparam int SELW = sel_width(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [N-1:0]     gnt;
  logic [N-1:0]     req;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             free;
  logic             xfer;

  assign free = !out_valid || out_ready;
  assign xfer = (|gnt) && free && rst_n;

  // req is what in_ready follows; in select mode it ignores the channel's own valid.
  assign in_ready = rst_n ? (req & {N{free}}) : '0;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] ptr;

      rr_grant #(.N(N), .SELW(SELW)) u_rr_grant (
        .valid (in_valid),
        .ptr   (ptr),
        .gnt   (gnt),
        .idx   (gnt_idx)
      );

      assign req = gnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr <= '0;
        end else if (xfer) begin
          ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + SELW'(1);
        end
      end
    end else begin : g_sel
      always_comb begin
        req     = '0;
        gnt     = '0;
        gnt_idx = sel;
        if (int'(sel) < N) begin
          req[sel] = 1'b1;
          gnt[sel] = in_valid[sel];
        end
      end
    end
  endgenerate

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) gnt_data = gnt_data | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Load takes priority over drain so a word can leave and arrive in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= gnt_data;
      out_chan  <= gnt_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_stream_nx1.sv
// tb/tb_mux_stream_nx1.sv - directed bench for mux_stream_nx1 in select and round-robin modes
module tb_mux_stream_nx1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] in_data0, in_data1;
  logic [3:0]  in_valid0, in_valid1, in_ready0, in_ready1;
  logic [1:0]  sel0, sel1, out_chan0, out_chan1;
  logic [3:0]  out_data0, out_data1;
  logic        out_valid0, out_valid1, out_ready0, out_ready1;

  int tests_run    = 0;
  int tests_failed = 0;

  mux_stream_nx1 #(.WIDTH(4), .N(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data0), .in_valid(in_valid0),
    .in_ready(in_ready0), .sel(sel0), .out_data(out_data0), .out_chan(out_chan0),
    .out_valid(out_valid0), .out_ready(out_ready0)
  );

  mux_stream_nx1 #(.WIDTH(4), .N(4), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data1), .in_valid(in_valid1),
    .in_ready(in_ready1), .sel(sel1), .out_data(out_data1), .out_chan(out_chan1),
    .out_valid(out_valid1), .out_ready(out_ready1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    in_data0 = '0; in_valid0 = '0; sel0 = '0; out_ready0 = 1'b0;
    in_data1 = '0; in_valid1 = '0; sel1 = '0; out_ready1 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid0 !== 1'b0 || out_data0 !== 4'h0 || out_chan0 !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: valid=%b data=%h chan=%0d, want 0/0/0", out_valid0, out_data0, out_chan0);
    end
    tests_run++;
    if (in_ready0 !== 4'b0000 || in_ready1 !== 4'b0000 || out_valid1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready: rdy0=%b rdy1=%b v1=%b, want 0000/0000/0", in_ready0, in_ready1, out_valid1);
    end
    tick;
    tick;
    rst_n = 1'b1;
    in_data0 = 16'hDCBA; in_valid0 = 4'b1111; sel0 = 2'd1; out_ready0 = 1'b1;
    tick;
    tests_run++;
    if (out_valid0 !== 1'b1 || out_data0 !== 4'hB) begin
      tests_failed++;
      $display("FAIL reset_pre_load: valid=%b data=%h, want 1/b", out_valid0, out_data0);
    end
    #3 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid0 !== 1'b0 || out_data0 !== 4'h0 || out_chan0 !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_async: valid=%b data=%h chan=%0d, want 0/0/0", out_valid0, out_data0, out_chan0);
    end
    #2 rst_n = 1'b1;
    sel0 = 2'd2;
    #1;
    tests_run++;
    if (in_ready0 !== 4'b0100) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got %b want 0100", in_ready0);
    end
    tick;
    tests_run++;
    if (out_valid0 !== 1'b1 || out_data0 !== 4'hC || out_chan0 !== 2'd2) begin
      tests_failed++;
      $display("FAIL reset_first_word: valid=%b data=%h chan=%0d, want 1/c/2", out_valid0, out_data0, out_chan0);
    end
    in_valid0 = 4'b0000;
    tick;
  endtask

  task automatic test_select;
    in_data0 = 16'hDCBA; in_valid0 = 4'b1111; sel0 = 2'd2; out_ready0 = 1'b1;
    #1;
    tests_run++;
    if (in_ready0 !== 4'b0100) begin
      tests_failed++;
      $display("FAIL sel_ready: got %b want 0100", in_ready0);
    end
    tick;
    tests_run++;
    if (out_valid0 !== 1'b1 || out_data0 !== 4'hC || out_chan0 !== 2'd2) begin
      tests_failed++;
      $display("FAIL sel_out: valid=%b data=%h chan=%0d, want 1/c/2", out_valid0, out_data0, out_chan0);
    end
    in_valid0 = 4'b1011;
    #1;
    tests_run++;
    if (in_ready0 !== 4'b0100) begin
      tests_failed++;
      $display("FAIL sel_ready_no_valid: got %b want 0100", in_ready0);
    end
    tick;
    tests_run++;
    if (out_valid0 !== 1'b0 || out_data0 !== 4'hC) begin
      tests_failed++;
      $display("FAIL sel_drop: valid=%b data=%h, want 0/c", out_valid0, out_data0);
    end
  endtask

  task automatic test_stall;
    in_data0 = 16'hDCBA; in_valid0 = 4'b1111; sel0 = 2'd0; out_ready0 = 1'b1;
    tick;
    out_ready0 = 1'b0;
    sel0 = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests_run++;
      if (in_ready0 !== 4'b0000) begin
        tests_failed++;
        $display("FAIL stall_ready[%0d]: got %b want 0000", k, in_ready0);
      end
      tick;
      tests_run++;
      if (out_valid0 !== 1'b1 || out_data0 !== 4'hA || out_chan0 !== 2'd0) begin
        tests_failed++;
        $display("FAIL stall_hold[%0d]: valid=%b data=%h chan=%0d, want 1/a/0", k, out_valid0, out_data0, out_chan0);
      end
    end
    out_ready0 = 1'b1;
    in_valid0 = 4'b0010;
    #1;
    tests_run++;
    if (in_ready0 !== 4'b0010) begin
      tests_failed++;
      $display("FAIL stall_release_ready: got %b want 0010", in_ready0);
    end
    tick;
    tests_run++;
    if (out_valid0 !== 1'b1 || out_data0 !== 4'hB || out_chan0 !== 2'd1) begin
      tests_failed++;
      $display("FAIL stall_no_bubble: valid=%b data=%h chan=%0d, want 1/b/1", out_valid0, out_data0, out_chan0);
    end
    in_valid0 = 4'b0000;
    tick;
    tests_run++;
    if (out_valid0 !== 1'b0) begin
      tests_failed++;
      $display("FAIL stall_drain: valid=%b want 0", out_valid0);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_alt [4];
    exp_alt[0] = 2'd1; exp_alt[1] = 2'd3; exp_alt[2] = 2'd1; exp_alt[3] = 2'd3;
    in_data1 = 16'hDCBA; out_ready1 = 1'b1; in_valid1 = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      tick;
      tests_run++;
      if (out_valid1 !== 1'b1 || out_chan1 !== 2'(k % 4) || out_data1 !== 4'(4'hA + k % 4)) begin
        tests_failed++;
        $display("FAIL rr_all[%0d]: valid=%b chan=%0d data=%h, want 1/%0d/%h", k, out_valid1, out_chan1, out_data1, k % 4, 4'(4'hA + k % 4));
      end
    end
    in_valid1 = 4'b0001;
    tick;
    tests_run++;
    if (out_chan1 !== 2'd0 || out_data1 !== 4'hA) begin
      tests_failed++;
      $display("FAIL rr_realign: chan=%0d data=%h, want 0/a", out_chan1, out_data1);
    end
    in_valid1 = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      tick;
      tests_run++;
      if (out_valid1 !== 1'b1 || out_chan1 !== exp_alt[k]) begin
        tests_failed++;
        $display("FAIL rr_sparse[%0d]: valid=%b chan=%0d, want 1/%0d", k, out_valid1, out_chan1, exp_alt[k]);
      end
    end
    in_valid1 = 4'b0000;
    tick;
  endtask

  task automatic test_wrap;
    in_data1 = 16'hDCBA; out_ready1 = 1'b1;
    in_valid1 = 4'b0100;
    tick;
    in_valid1 = 4'b0001;
    #1;
    tests_run++;
    if (in_ready1 !== 4'b0001) begin
      tests_failed++;
      $display("FAIL wrap_ready: got %b want 0001", in_ready1);
    end
    tick;
    tests_run++;
    if (out_chan1 !== 2'd0 || out_data1 !== 4'hA) begin
      tests_failed++;
      $display("FAIL wrap_ch0: chan=%0d data=%h, want 0/a", out_chan1, out_data1);
    end
    in_valid1 = 4'b1001;
    tick;
    tests_run++;
    if (out_valid1 !== 1'b1 || out_chan1 !== 2'd3 || out_data1 !== 4'hD) begin
      tests_failed++;
      $display("FAIL wrap_ch3: valid=%b chan=%0d data=%h, want 1/3/d", out_valid1, out_chan1, out_data1);
    end
    in_valid1 = 4'b0000;
    tick;
    tests_run++;
    if (out_valid1 !== 1'b0) begin
      tests_failed++;
      $display("FAIL wrap_drain: valid=%b want 0", out_valid1);
    end
  endtask

  task automatic test_back_to_back;
    sel0 = 2'd0; out_ready0 = 1'b1; in_valid0 = 4'b0001; in_data0 = 16'h0000;
    for (int k = 0; k < 16; k++) begin
      in_data0[3:0] = 4'(k);
      tick;
      tests_run++;
      if (out_valid0 !== 1'b1 || out_data0 !== 4'(k) || out_chan0 !== 2'd0) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: valid=%b data=%h chan=%0d, want 1/%h/0", k, out_valid0, out_data0, out_chan0, 4'(k));
      end
    end
    in_valid0 = 4'b0000;
    tick;
    tests_run++;
    if (out_valid0 !== 1'b0 || out_data0 !== 4'hF) begin
      tests_failed++;
      $display("FAIL b2b_end: valid=%b data=%h, want 0/f", out_valid0, out_data0);
    end
  endtask

  initial begin
    test_reset;
    test_select;
    test_stall;
    test_round_robin;
    test_wrap;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
